// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/done handshake and result bus of the multi-cycle ALU
// Signal names follow the execute-stage port list; the master is the pipeline.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             zero_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  ready_o, busy_o, done_o, result_o, hi_o, zero_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output ready_o, busy_o, done_o, result_o, hi_o, zero_o
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle logic/arith ops, shift-add MUL, restoring DIVU
// One start/done handshake for every op; results are registered and held between completions.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic   clk_i,
  input  logic   rst_i,
  seq_alu_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_DIVU = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   result, hi;
  logic               zero;

  logic               accept, is_long, last_iter;
  logic [WIDTH-1:0]   simple_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step;

  assign accept    = bus.start_i && (state != RUN);
  assign is_long   = (bus.ctrl_i == OP_MUL) || (bus.ctrl_i == OP_DIVU);
  assign last_iter = (cnt == CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = is_long ? RUN : DONE;
      end
      RUN: begin
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        if (accept) next_state = is_long ? RUN : DONE;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Simple ops are evaluated from the live inputs so the result lands on the accept edge.
  always_comb begin
    simple_res = '0;
    case (bus.ctrl_i)
      OP_AND:  simple_res = bus.src1_i & bus.src2_i;
      OP_OR:   simple_res = bus.src1_i | bus.src2_i;
      OP_ADD:  simple_res = bus.src1_i + bus.src2_i;
      OP_SUB:  simple_res = bus.src1_i - bus.src2_i;
      OP_SLTU: simple_res = (bus.src1_i < bus.src2_i) ? WIDTH'(1) : '0;
      OP_SLT:  simple_res = ($signed(bus.src1_i) < $signed(bus.src2_i)) ? WIDTH'(1) : '0;
      OP_NOR:  simple_res = ~(bus.src1_i | bus.src2_i);
      default: simple_res = '0;
    endcase
  end

  // MUL: acc = {partial product, multiplier}; the add carry becomes the new top bit on shift.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  end

  // DIVU: acc = {remainder, dividend/quotient}. A zero divisor naturally yields all-ones / A.
  always_comb begin
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (trial >= {1'b0, b_q});
    diff     = trial[WIDTH-1:0] - b_q;
    div_next = {(ge ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};
  end

  assign step = (op_q == OP_MUL) ? mul_next : div_next;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      acc    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      hi     <= '0;
      zero   <= 1'b1;
    end else if (accept) begin
      op_q <= bus.ctrl_i;
      a_q  <= bus.src1_i;
      b_q  <= bus.src2_i;
      if (is_long) begin
        cnt <= CNT_W'(WIDTH);
        acc <= (bus.ctrl_i == OP_MUL) ? {{WIDTH{1'b0}}, bus.src2_i}
                                      : {{WIDTH{1'b0}}, bus.src1_i};
      end else begin
        result <= simple_res;
        hi     <= '0;
        zero   <= (simple_res == '0);
      end
    end else if (state == RUN) begin
      acc <= step;
      cnt <= cnt - CNT_W'(1);
      if (last_iter) begin
        result <= step[WIDTH-1:0];
        hi     <= step[2*WIDTH-1:WIDTH];
        zero   <= (step[WIDTH-1:0] == '0);
      end
    end
  end

  assign bus.ready_o  = (state != RUN);
  assign bus.busy_o   = (state == RUN);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = result;
  assign bus.hi_o     = hi;
  assign bus.zero_o   = zero;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu: vector table, random ops vs model, corner sequences
// Inputs change just after a clock edge; outputs are sampled 1 time unit after the rising edge.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus();

  seq_alu #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] h;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] h);
    logic [63:0] p;
    r = 32'h0;
    h = 32'h0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1110: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
        h = p[63:32];
      end
      4'b1111: begin
        if (b == 32'h0) begin
          r = 32'hFFFF_FFFF;
          h = a;
        end else begin
          r = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [31:0] h, output logic z,
                       output int lat);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ctrl_i  = c;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'($urandom);
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    lat = 1;
    while (!bus.done_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus.result_o;
    h = bus.hi_o;
    z = bus.zero_o;
  endtask

  task automatic run_checked(input string tag, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] er, input logic [31:0] eh,
                             input int elat);
    logic [31:0] r, h;
    logic        z;
    int          lat;
    do_op(c, a, b, r, h, z, lat);
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " result"}, 64'(r), 64'(er));
    check({tag, " hi"}, 64'(h), 64'(eh));
    check({tag, " zero"}, 64'(z), 64'(er == 32'h0));
  endtask

  initial begin
    logic [31:0] er, eh;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    int          busy_cnt;
    int          guard;

    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'h0;
    bus.src1_i  = 32'h0;
    bus.src2_i  = 32'h0;

    vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1};
    vecs[1]  = '{4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 32'h0, 1};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1};
    vecs[3]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1};
    vecs[4]  = '{4'b0000, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 32'h0, 1};
    vecs[5]  = '{4'b0001, 32'h0000_00F0, 32'h0000_003C, 32'h0000_00FC, 32'h0, 1};
    vecs[6]  = '{4'b1100, 32'h0000_00F0, 32'h0000_003C, 32'hFFFF_FF03, 32'h0, 1};
    vecs[7]  = '{4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 32'h0, 1};
    vecs[8]  = '{4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33};
    vecs[9]  = '{4'b1111, 32'd100,       32'd7,         32'd14,        32'd2, 33};
    vecs[10] = '{4'b1111, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9, 33};
    vecs[11] = '{4'b1110, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 33};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset result", 64'(bus.result_o), 64'h0);
    check("reset hi", 64'(bus.hi_o), 64'h0);
    check("reset zero", 64'(bus.zero_o), 64'h1);
    check("reset ready", 64'(bus.ready_o), 64'h1);
    check("reset busy", 64'(bus.busy_o), 64'h0);
    check("reset done", 64'(bus.done_o), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("idle done", 64'(bus.done_o), 64'h0);

    for (int i = 0; i < 12; i++) begin
      run_checked($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b,
                  vecs[i].r, vecs[i].h, vecs[i].lat);
    end

    for (int i = 0; i < 24; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = (i % 5 == 1) ? 32'($urandom_range(0, 300)) : $urandom;
      rb = (i % 6 == 2) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom);
      model(rc, ra, rb, er, eh);
      run_checked($sformatf("rand%0d op%0h", i, rc), rc, ra, rb, er, eh,
                  (rc == 4'b1110 || rc == 4'b1111) ? 33 : 1);
    end

    // MUL with a start pulse injected mid-RUN; it must not disturb the iteration.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'b1110;
    bus.src1_i  = 32'hFFFF_FFFF;
    bus.src2_i  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    busy_cnt = 0;
    guard    = 0;
    while (bus.busy_o && guard < 100) begin
      busy_cnt++;
      bus.start_i = (busy_cnt == 5);
      bus.ctrl_i  = 4'b0010;
      bus.src1_i  = 32'd1;
      bus.src2_i  = 32'd1;
      check("mid-run ready low", 64'(bus.ready_o), 64'h0);
      @(posedge clk);
      #1;
      guard++;
    end
    bus.start_i = 1'b0;
    check("mid-run busy cycles", 64'(busy_cnt), 64'd32);
    check("mid-run done", 64'(bus.done_o), 64'h1);
    check("mid-run result", 64'(bus.result_o), 64'h1);
    check("mid-run hi", 64'(bus.hi_o), 64'hFFFF_FFFE);
    @(posedge clk);
    #1;
    check("mid-run no extra done", 64'(bus.done_o), 64'h0);

    // Back-to-back simple ops: second accepted in the first one's DONE cycle.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'b0010;
    bus.src1_i  = 32'd1;
    bus.src2_i  = 32'd2;
    @(posedge clk);
    #1;
    check("b2b first done", 64'(bus.done_o), 64'h1);
    check("b2b first result", 64'(bus.result_o), 64'd3);
    bus.ctrl_i = 4'b0000;
    bus.src1_i = 32'h0000_00F0;
    bus.src2_i = 32'h0000_003C;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    check("b2b second done", 64'(bus.done_o), 64'h1);
    check("b2b second result", 64'(bus.result_o), 64'h30);
    @(posedge clk);
    #1;
    check("b2b done drops", 64'(bus.done_o), 64'h0);
    check("b2b result held", 64'(bus.result_o), 64'h30);

    // Reset at cycle T+10 of a MUL abandons it.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'b1110;
    bus.src1_i  = 32'h0000_1234;
    bus.src2_i  = 32'h0000_5678;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre-reset busy", 64'(bus.busy_o), 64'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst-run result", 64'(bus.result_o), 64'h0);
    check("rst-run hi", 64'(bus.hi_o), 64'h0);
    check("rst-run zero", 64'(bus.zero_o), 64'h1);
    check("rst-run ready", 64'(bus.ready_o), 64'h1);
    check("rst-run busy", 64'(bus.busy_o), 64'h0);
    check("rst-run done", 64'(bus.done_o), 64'h0);
    repeat (40) @(posedge clk);
    #1;
    check("rst-run stays idle", 64'(bus.done_o), 64'h0);
    run_checked("post-reset add", 4'b0010, 32'd2, 32'd2, 32'd4, 32'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised ALU for the pipelined CPU's execute stage. It keeps the single-cycle ALU operation encoding and adds two operations: an iterative shift-add multiply with a full double-width product, and a restoring unsigned divide. Every operation uses a start/done handshake, so the hazard unit can stall the pipeline on `busy_o`. Results are registered and held until the next completion.

## Interface
- `WIDTH`, 32: operand and result width, ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: width of the iteration counter.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `start_i`  in  1  request; sampled only when `ready_o`=1.
- `ctrl_i`  in  4  operation code, latched with the operands.
- `src1_i`  in  WIDTH  operand A.
- `src2_i`  in  WIDTH  operand B.
- `ready_o`  out  1  block can accept `start_i` this cycle.
- `busy_o`  out  1  a multiply or divide is iterating.
- `done_o`  out  1  one-cycle pulse: `result_o`/`hi_o`/`zero_o` updated this cycle.
- `result_o`  out  WIDTH  primary result.
- `hi_o`  out  WIDTH  product high half, or divide remainder; 0 for other operations.
- `zero_o`  out  1  `result_o`==0.

## Operation
- States: IDLE, RUN, DONE.
- `ready_o` = (state≠RUN). `busy_o` = (state==RUN).
- Accept rule: a start is accepted when `start_i`=1 and `ready_o`=1. On accept, `ctrl_i`, `src1_i` and `src2_i` are latched.
- Simple operations go directly to DONE:
  - 0000 AND; 0001 OR.
  - 0010 ADD; 0110 SUB: modulo 2^WIDTH, carry/borrow dropped.
  - 0111 SLTU: unsigned A<B → 1, else 0.
  - 1000 SLT: signed compare → 1, else 0.
  - 1100 NOR.
  - Any other code: result 0, `hi_o` 0. There is no error flag.
- 1110 MUL (unsigned):
  - Accept → RUN with counter=WIDTH.
  - Each RUN cycle: if multiplier LSB=1, add multiplicand to the upper half of a 2·WIDTH accumulator; then shift right by 1.
  - Counter==1 at the end of a cycle → DONE.
  - Output: `result_o`=product[WIDTH-1:0], `hi_o`=product[2·WIDTH-1:WIDTH].
- 1111 DIVU:
  - Restoring division, one quotient bit per RUN cycle, WIDTH cycles.
  - Output: `result_o`=quotient, `hi_o`=remainder.
  - Divide by zero: quotient all-ones, remainder=A; still takes WIDTH RUN cycles.
- DONE:
  - `result_o`, `hi_o` and `zero_o` are written on entry; `done_o`=1 for exactly this one cycle.
  - Next state: if a new start is accepted here, RUN (MUL/DIVU) or DONE again (simple op); otherwise IDLE.
- Outputs hold their last value in IDLE and RUN.
- `start_i` during RUN is ignored; it is not queued.
- Reset (`rst_i`=0 at an edge) overrides everything, including an operation in RUN, which is abandoned:
  - state IDLE, counter 0;
  - `result_o`=0, `hi_o`=0, `zero_o`=1, `done_o`=0;
  - `ready_o`=1, `busy_o`=0.
- Inputs can change freely after the accept edge; only the latched copies are used.

## Timing
- Accept edge is T.
- Simple op: state=DONE and `done_o`=1 in cycle T+1 (latency 1).
- MUL/DIVU: RUN for cycles T+1 … T+WIDTH; DONE and `done_o`=1 in cycle T+WIDTH+1 (latency WIDTH+1; 33 at WIDTH=32).
- Back-to-back simple ops: one result per cycle; `done_o` stays high on consecutive cycles.
- `zero_o` is always consistent with `result_o`, including the reset value.

## Test plan
- Reset, then idle: `result_o`=0, `hi_o`=0, `zero_o`=1, `ready_o`=1, `busy_o`=0, `done_o`=0.
- Simple ops (WIDTH=32):
  - ADD 0xFFFFFFFF+1 → result 0, `zero_o`=1, `done_o` 1 cycle after start.
  - SUB 5−7 → 0xFFFFFFFE.
  - SLTU 0xFFFFFFFF<1 → 0; SLT same operands → 1.
- MUL 0xFFFFFFFF×0xFFFFFFFF:
  - `busy_o` for 32 cycles, `done_o` at T+33;
  - result 0x00000001, `hi_o` 0xFFFFFFFE;
  - `start_i` pulsed mid-RUN has no effect.
- DIVU:
  - 100÷7 → result 14, `hi_o` 2.
  - 9÷0 → result 0xFFFFFFFF, `hi_o` 9; both complete at T+33.
- Back-to-back: ADD 1+2 accepted, then AND 0xF0&0x3C accepted in its DONE cycle → `done_o` high for 2 consecutive cycles, results 3 then 0x30.
- Reset mid-run: assert `rst_i`=0 at cycle T+10 of a MUL → next cycle in IDLE with all outputs at reset values. A new ADD 2+2 afterwards → 4.
